// File: rtl/fetch_seq.sv
// fetch_seq: fetch sequencer for a single-cycle instruction ROM.
// Owns the program counter and registers each ROM word into a one-entry slot.
// Decode drains the slot with a valid/ready handshake.
// Handles control-flow redirects.
// Optional feature macro: FETCH_HALT_EN enables halt-opcode detection and the HALT state.
// Without FETCH_HALT_EN, halted is tied low.
module fetch_seq #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INS_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic             clk,
    input  logic             rstd,
    output logic [PC_W-1:0]  mem_addr,
    input  logic [INS_W-1:0] mem_ins,
    output logic [INS_W-1:0] ins_out,
    output logic [PC_W-1:0]  ins_pc,
    output logic             ins_valid,
    input  logic             ins_ready,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             halted,
    output logic [15:0]      fetch_count
);

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic [PC_W-1:0]  ins_pc_q, ins_pc_d;
    logic             valid_q, valid_d;
    logic [15:0]      cnt_q, cnt_d;

    logic accept;
    logic slot_free;
    logic halt_hit;

    assign accept    = valid_q && ins_ready;
    assign slot_free = !valid_q || ins_ready;
    // Only meaningful when halt detection is compiled in.
    assign halt_hit  = HaltEn && (mem_ins[31:26] == HALT_OP);

    // Next-state logic: redirect beats fetch, halt freezes the pc at the halt address.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        ins_pc_d = ins_pc_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q + 16'(accept);
        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (slot_free) begin
                    ins_d    = mem_ins;
                    ins_pc_d = pc_q;
                    valid_d  = 1'b1;
                    if (halt_hit) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StHalt: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = StRun;
                end else if (accept) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q  <= StRun;
            pc_q     <= '0;
            ins_q    <= '0;
            ins_pc_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            ins_pc_q <= ins_pc_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_addr    = pc_q;
    assign ins_out     = ins_q;
    assign ins_pc      = ins_pc_q;
    assign ins_valid   = valid_q;
    assign fetch_count = cnt_q;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed vector table for fetch_seq.
// Also runs a randomized run against a cycle-level reference model.
// Model: FETCH_HALT_EN (when defined) enables halt behaviour in both DUT and model.
module tb_fetch_seq;

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    logic        clk;
    logic        rstd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_ins;
    logic [31:0] ins_out;
    logic [7:0]  ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] rom [256];

    int n_cmp;
    int n_fail;

    typedef struct {
        bit          ready;
        bit          redir;
        logic [7:0]  rpc;
        bit          ev;
        logic [7:0]  epc;
        logic [31:0] eins;
        logic [7:0]  eaddr;
        logic [15:0] ecnt;
        bit          eh;
    } vec_t;

    vec_t vecs[$];

    fetch_seq dut (
        .clk         (clk),
        .rstd        (rstd),
        .mem_addr    (mem_addr),
        .mem_ins     (mem_ins),
        .ins_out     (ins_out),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign mem_ins = rom[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, 32'(ins_valid), 32'd0);
        chk({tag, ".ins_pc"}, 32'(ins_pc), 32'd0);
        chk({tag, ".ins_out"}, ins_out, 32'd0);
        chk({tag, ".addr"}, 32'(mem_addr), 32'd0);
        chk({tag, ".cnt"}, 32'(fetch_count), 32'd0);
        chk({tag, ".halted"}, 32'(halted), 32'd0);
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later.
    task automatic step(input bit rdy, input bit rd, input logic [7:0] rpc);
        ins_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit rdy, input bit rd, input logic [7:0] rpc, input bit ev,
                       input logic [7:0] epc, input logic [31:0] eins, input logic [7:0] eaddr,
                       input logic [15:0] ecnt, input bit eh);
        vecs.push_back(vec_t'{rdy, rd, rpc, ev, epc, eins, eaddr, ecnt, eh});
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            step(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("%s[%0d].valid", tag, i), 32'(ins_valid), 32'(vecs[i].ev));
            chk($sformatf("%s[%0d].ins_pc", tag, i), 32'(ins_pc), 32'(vecs[i].epc));
            chk($sformatf("%s[%0d].ins_out", tag, i), ins_out, vecs[i].eins);
            chk($sformatf("%s[%0d].addr", tag, i), 32'(mem_addr), 32'(vecs[i].eaddr));
            chk($sformatf("%s[%0d].cnt", tag, i), 32'(fetch_count), 32'(vecs[i].ecnt));
            chk($sformatf("%s[%0d].halted", tag, i), 32'(halted), 32'(vecs[i].eh));
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstd = 1'b0;
        @(negedge clk);
        rstd = 1'b1;
    endtask

    // Reference model state.
    bit          m_v;
    bit          m_halt;
    logic [7:0]  m_pc;
    logic [7:0]  m_ipc;
    logic [31:0] m_ins;
    logic [15:0] m_cnt;

    task automatic model_cycle(input bit rdy, input bit rd, input logic [7:0] rpc);
        logic [31:0] w;
        bit acc;
        acc = m_v && rdy;
        if (acc) m_cnt = m_cnt + 16'd1;
        if (rd) begin
            m_pc   = rpc;
            m_v    = 1'b0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            if (acc) m_v = 1'b0;
        end else if (!m_v || rdy) begin
            w     = rom[m_pc];
            m_ins = w;
            m_ipc = m_pc;
            m_v   = 1'b1;
            if (HaltEn && w[31:26] == 6'h3f) m_halt = 1'b1;
            else m_pc = 8'((int'(m_pc) + 1) % 256);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        ins_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 32'(i + 100);

        // Power-on reset: values must be visible while rstd is low.
        rstd = 1'b0;
        #19;
        chk_reset_vals("por");
        #1;
        rstd = 1'b1;

        // Streaming, stall at ins_pc=5, redirect with stalled slot, wrap at 0xFF.
        add(1, 0, 8'h00, 1, 8'h00, 32'd100, 8'h01, 16'd0,  0);
        add(1, 0, 8'h00, 1, 8'h01, 32'd101, 8'h02, 16'd1,  0);
        add(1, 0, 8'h00, 1, 8'h02, 32'd102, 8'h03, 16'd2,  0);
        add(1, 0, 8'h00, 1, 8'h03, 32'd103, 8'h04, 16'd3,  0);
        add(1, 0, 8'h00, 1, 8'h04, 32'd104, 8'h05, 16'd4,  0);
        add(1, 0, 8'h00, 1, 8'h05, 32'd105, 8'h06, 16'd5,  0);
        add(0, 0, 8'h00, 1, 8'h05, 32'd105, 8'h06, 16'd5,  0);
        add(0, 0, 8'h00, 1, 8'h05, 32'd105, 8'h06, 16'd5,  0);
        add(0, 0, 8'h00, 1, 8'h05, 32'd105, 8'h06, 16'd5,  0);
        add(1, 0, 8'h00, 1, 8'h06, 32'd106, 8'h07, 16'd6,  0);
        add(1, 0, 8'h00, 1, 8'h07, 32'd107, 8'h08, 16'd7,  0);
        add(0, 1, 8'h40, 0, 8'h07, 32'd107, 8'h40, 16'd7,  0);
        add(1, 0, 8'h00, 1, 8'h40, 32'd164, 8'h41, 16'd7,  0);
        add(1, 1, 8'hfe, 0, 8'h40, 32'd164, 8'hfe, 16'd8,  0);
        add(1, 0, 8'h00, 1, 8'hfe, 32'd354, 8'hff, 16'd8,  0);
        add(1, 0, 8'h00, 1, 8'hff, 32'd355, 8'h00, 16'd9,  0);
        add(1, 0, 8'h00, 1, 8'h00, 32'd100, 8'h01, 16'd10, 0);
        add(1, 0, 8'h00, 1, 8'h01, 32'd101, 8'h02, 16'd11, 0);
        run_vecs("stream");

        // Asynchronous reset between edges while ins_pc=7 sits in the slot.
        step(1, 1, 8'h07);
        step(0, 0, 8'h00);
        chk("mid.pre_pc", 32'(ins_pc), 32'h07);
        chk("mid.pre_valid", 32'(ins_valid), 32'd1);
        #2;
        rstd = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        rstd = 1'b1;
        add(1, 0, 8'h00, 1, 8'h00, 32'd100, 8'h01, 16'd0, 0);
        run_vecs("restart");

        // Halt opcode at address 3.
        do_reset();
        rom[3] = {6'b111111, 26'd0};
        add(1, 0, 8'h00, 1, 8'h00, 32'd100,       8'h01, 16'd0, 0);
        add(1, 0, 8'h00, 1, 8'h01, 32'd101,       8'h02, 16'd1, 0);
        add(1, 0, 8'h00, 1, 8'h02, 32'd102,       8'h03, 16'd2, 0);
`ifdef FETCH_HALT_EN
        add(1, 0, 8'h00, 1, 8'h03, 32'hfc000000, 8'h03, 16'd3, 1);
        add(0, 0, 8'h00, 1, 8'h03, 32'hfc000000, 8'h03, 16'd3, 1);
        add(1, 0, 8'h00, 0, 8'h03, 32'hfc000000, 8'h03, 16'd4, 1);
        add(1, 0, 8'h00, 0, 8'h03, 32'hfc000000, 8'h03, 16'd4, 1);
        add(0, 1, 8'h10, 0, 8'h03, 32'hfc000000, 8'h10, 16'd4, 0);
        add(1, 0, 8'h00, 1, 8'h10, 32'd116,       8'h11, 16'd4, 0);
`else
        add(1, 0, 8'h00, 1, 8'h03, 32'hfc000000, 8'h04, 16'd3, 0);
        add(1, 0, 8'h00, 1, 8'h04, 32'd104,       8'h05, 16'd4, 0);
`endif
        run_vecs("halt");

        // Randomized run against the reference model.
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
            if ($urandom_range(0, 7) == 0) rom[i] = {6'b111111, rom[i][25:0]};
        end
        do_reset();
        m_v = 0; m_halt = 0; m_pc = '0; m_ipc = '0; m_ins = '0; m_cnt = '0;
        for (int c = 0; c < 600; c++) begin
            bit          rdy;
            bit          rd;
            logic [7:0]  rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = 8'($urandom);
            model_cycle(rdy, rd, rpc);
            step(rdy, rd, rpc);
            chk($sformatf("rnd[%0d].valid", c), 32'(ins_valid), 32'(m_v));
            chk($sformatf("rnd[%0d].ins_pc", c), 32'(ins_pc), 32'(m_ipc));
            chk($sformatf("rnd[%0d].ins_out", c), ins_out, m_ins);
            chk($sformatf("rnd[%0d].addr", c), 32'(mem_addr), 32'(m_pc));
            chk($sformatf("rnd[%0d].cnt", c), 32'(fetch_count), 32'(m_cnt));
            chk($sformatf("rnd[%0d].halted", c), 32'(halted), 32'(m_halt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch sequencer for the single-cycle instruction ROM. It owns the program counter, drives the ROM address, and registers each returned instruction into a one-entry output slot. The slot is handed to decode with a valid/ready handshake. The block also handles control-flow redirects and halt detection, and sits between the instruction ROM (combinational read) and the decode stage.

## Interface
Parameters:
- PC_W, 8, program counter / ROM address width
- INS_W, 32, instruction width
- HALT_OP, 6'b111111, opcode value (ins[31:26]) recognised as halt

Ports:
- clk  input  1  clock, rising-edge active
- rstd  input  1  reset, asynchronous, active-low
- mem_addr  output  PC_W  ROM read address; combinationally equal to pc
- mem_ins  input  INS_W  ROM read data for mem_addr, valid in the same cycle
- ins_out  output  INS_W  registered instruction presented to decode
- ins_pc  output  PC_W  address ins_out was fetched from
- ins_valid  output  1  ins_out/ins_pc hold a valid instruction
- ins_ready  input  1  decode accepts ins_out this cycle
- redirect  input  1  load redirect_pc and flush the slot
- redirect_pc  input  PC_W  redirect target
- halted  output  1  sequencer is in HALT
- fetch_count  output  16  number of instructions accepted by decode (ins_valid && ins_ready)

## Operation
- State machine has two states, RUN and HALT. Reset state is RUN.
- Slot free condition: free = !ins_valid || ins_ready.
- RUN, redirect=1 (highest priority):
  - pc <= redirect_pc
  - ins_valid <= 0; any slot content is dropped even if ins_ready=1
  - fetch_count still increments if ins_valid && ins_ready
- RUN, redirect=0, free=1:
  - ins_out <= mem_ins; ins_pc <= pc; ins_valid <= 1
  - pc <= pc+1, modulo 2^PC_W (255 -> 0 wraps silently)
- RUN, redirect=0, free=0 (stall): pc, ins_out, ins_pc and ins_valid hold unchanged.
- Halt capture: when an instruction is captured with mem_ins[31:26]==HALT_OP:
  - the instruction is still loaded into the slot
  - pc does not advance; it stays at the halt address
  - state -> HALT
- HALT:
  - No new fetch.
  - The halt instruction stays in the slot until accepted; then ins_valid <= 0.
  - pc holds.
  - redirect=1: pc <= redirect_pc, ins_valid <= 0, state -> RUN. This is the only exit from HALT besides reset.
- fetch_count increments on every cycle with ins_valid && ins_ready, in any state. It wraps at 2^16.
- Reset mid-operation (rstd low at any time) immediately forces all reset values below, independent of clk.

## Timing
- Reset values:
  - pc = 0, mem_addr = 0
  - ins_out = 0, ins_pc = 0, ins_valid = 0
  - halted = 0, fetch_count = 0, state = RUN
- First rising edge after rstd rises captures ROM[0]: ins_valid=1, ins_pc=0, pc=1.
- Fetch latency: one clock from mem_addr to ins_out.
- Throughput: one instruction per clock while ins_ready=1.
- Redirect penalty: one bubble cycle.
  - Edge N samples redirect; ins_valid=0 after edge N.
  - Edge N+1 captures ROM[redirect_pc].
- halted is registered and asserts after the edge that captures the halt instruction.
- ins_ready is ignored when ins_valid=0.
- redirect and ins_ready may change every cycle. There is no combinational path from ins_ready or redirect to any output.

## Configuration
- FETCH_HALT_EN defined: halt detection and the HALT state behave as described above.
- FETCH_HALT_EN undefined:
  - HALT_OP is treated as an ordinary instruction and the state machine stays in RUN.
  - halted is tied to 0.
  - The HALT_OP parameter is present but unused.

## Test plan
- Reset and streaming: ROM[i]=i+100, rstd low 20 ns then high, ins_ready=1 -> ins_out 100,101,102 on consecutive edges, ins_pc 0,1,2, fetch_count=3 after third accept.
- Stall: assert ins_ready=0 while ins_pc=5 is in the slot, hold 3 cycles -> ins_out/ins_pc/mem_addr (6) frozen. Release -> ins_pc=6 next edge, nothing skipped or duplicated.
- Redirect: redirect=1, redirect_pc=0x40 with slot valid and ins_ready=0 -> next edge ins_valid=0. Following edge ins_pc=0x40, ins_out=ROM[0x40]. The dropped instruction is not counted.
- Wrap: redirect_pc=0xFE, streaming -> ins_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Halt (FETCH_HALT_EN): ROM[3]={6'b111111,26'd0} -> ins_pc=3 delivered, halted=1, mem_addr stays 3, ins_valid=0 after accept. Redirect to 0x10 -> halted=0, ins_pc=0x10.
- Async reset mid-stream: rstd low between clock edges while ins_pc=7 -> all outputs at reset values immediately. Restart fetches ROM[0].
